rtc_bus_secuenciador: RTL and testbench
=======================================

Name: rtc_bus_secuenciador

Overview:
- Transaction sequencer for the RTC multiplexed address/data bus.
- Sits directly upstream of the bidirectional data mux (logica_para_Escribir_Leer_Mux).
- Per accepted request, runs one address phase then one data phase (write or read). Generates RTC strobes (cs_n, ad, wr_n, rd_n) and the phase/direction flags that steer the mux.
- Captures read data returned by the mux and reports completion.

Parameters:
- T_SU, 2: setup cycles per phase, before strobe; range 1..255.
- T_PW, 10: strobe low-width cycles per phase; range 1..255.
- T_HD, 2: hold cycles per phase, after strobe; range 1..255.
- T_GAP, 4: idle cycles between address phase and data phase; cs_n high; range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  request strobe; sampled only in IDLE
- in_wr  in  1  request type: 1=write, 0=read
- in_addr  in  8  RTC register address
- in_wdata  in  8  write data
- dato_leido  in  8  read data from mux (its out_reg_dato)
- out_dato_mux  out  8  byte for mux to drive: address in addr phase, write data in data phase
- flag_direccion  out  1  high for whole address phase
- flag_dato  out  1  high for whole data phase
- controlador_dato  out  1  1 = mux drives bus, 0 = bus released
- cs_n  out  1  RTC chip select, active low
- ad  out  1  0 = address cycle, 1 = data cycle
- wr_n  out  1  write strobe, active low
- rd_n  out  1  read strobe, active low
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- rd_data  out  8  last captured read byte

Behaviour:
- All outputs registered. Reset values:
  - cs_n=1, wr_n=1, rd_n=1, ad=0
  - flags=0, controlador_dato=0
  - busy=0, done=0
  - rd_data=0x00, out_dato_mux=0x00
  - state=IDLE, counter=0
- States: IDLE, A_SU, A_PW, A_HD, GAP, D_SU, D_PW, D_HD, DONE.
- Each timed state lasts exactly its parameter count in cycles (8-bit down-counter, reloaded on entry); exits when counter==1.
- IDLE:
  - start=1 latches in_wr, in_addr, in_wdata and moves to A_SU.
  - busy=1 from the next cycle.
- Address phase (A_SU, A_PW, A_HD):
  - cs_n=0, ad=0, flag_direccion=1, controlador_dato=1, out_dato_mux=latched addr.
  - wr_n=0 only in A_PW.
- GAP: cs_n=1, all flags 0, controlador_dato=0.
- Data phase (D_SU, D_PW, D_HD):
  - cs_n=0, ad=1, flag_dato=1.
  - Write: controlador_dato=1, out_dato_mux=latched wdata, wr_n=0 only in D_PW.
  - Read: controlador_dato=0, rd_n=0 only in D_PW; rd_data loads dato_leido on the last D_PW cycle.
- DONE (1 cycle): done=1, busy=1, strobes idle, then IDLE.
- busy falls the cycle after DONE. A start in that same cycle is accepted.
- Total length: busy high for 2*(T_SU+T_PW+T_HD)+T_GAP+1 cycles (33 at defaults).
- start while busy: ignored, no queueing. Request inputs changing mid-transaction have no effect.
- wr_n and rd_n are never low simultaneously.
- controlador_dato is 0 whenever rd_n=0 and throughout GAP.
- reset mid-transaction: next edge forces all reset values. No strobe is extended, no done pulse, rd_data cleared.

Optional Feature:
- Macro RTCBUS_ERR_EN adds output err_ocupado (1 bit).
- With the macro:
  - Set to 1 when start=1 arrives while busy=1.
  - Sticky; cleared only by reset or by the next accepted start.
  - The ignored request is still discarded.
- Without the macro: port absent, behaviour otherwise identical.

Test Plan:
- Defaults; reset, then write in_addr=0x21, in_wdata=0x45 -> out_dato_mux=0x21 with wr_n low 10 cycles; cs_n high 4 cycles; then 0x45 with wr_n low 10 cycles; done at busy cycle 33; rd_n stays 1.
- Read in_addr=0x22, dato_leido=0x59 during D_PW -> controlador_dato=0 for the whole data phase, rd_n low 10 cycles, rd_data=0x59 when done=1.
- Pulse start at busy cycle 5 with in_addr=0x99 -> ignored; the transaction completes with the original address; with RTCBUS_ERR_EN, err_ocupado=1 until the next accepted start.
- Assert reset during D_PW of a write -> next cycle cs_n=wr_n=1, busy=0, rd_data=0x00, no done pulse.
- Back-to-back: start held high continuously -> new transaction begins the cycle after DONE; busy gap 1 cycle.
- Parameters T_SU=1, T_PW=1, T_HD=1, T_GAP=1 -> busy 8 cycles; each strobe 1 cycle low.

Source files
------------

// File: rtl/rtc_bus_secuenciador.sv
// RTC multiplexed address/data bus sequencer: address phase, gap, data phase.
// Define RTCBUS_ERR_EN to add the sticky err_ocupado output.
module rtc_bus_secuenciador #(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_PW  = 10,
  parameter int unsigned T_HD  = 2,
  parameter int unsigned T_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_wr,
  input  logic [7:0] in_addr,
  input  logic [7:0] in_wdata,
  input  logic [7:0] dato_leido,
  output logic [7:0] out_dato_mux,
  output logic       flag_direccion,
  output logic       flag_dato,
  output logic       controlador_dato,
  output logic       cs_n,
  output logic       ad,
  output logic       wr_n,
  output logic       rd_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data
`ifdef RTCBUS_ERR_EN
  ,
  output logic       err_ocupado
`endif
);

  localparam logic [7:0] SU8  = 8'(T_SU);
  localparam logic [7:0] PW8  = 8'(T_PW);
  localparam logic [7:0] HD8  = 8'(T_HD);
  localparam logic [7:0] GAP8 = 8'(T_GAP);

  typedef enum logic [3:0] {
    IDLE,
    A_SU,
    A_PW,
    A_HD,
    GAP,
    D_SU,
    D_PW,
    D_HD,
    DONE
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       last;
  logic       accept;

  logic       wr_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;

  logic       wr_l;
  logic [7:0] addr_l;
  logic [7:0] wdata_l;

  logic       in_a;
  logic       in_d;
  logic [7:0] mux_n;
  logic       cs_n_n;
  logic       ad_n;
  logic       wr_n_n;
  logic       rd_n_n;
  logic       cd_n;
  logic       busy_n;
  logic       done_n;

  assign last   = (cnt == 8'd1);
  assign accept = (state == IDLE) && start;

  // Request fields as seen by the next state, so the first
  // address-phase cycle already shows the freshly latched byte.
  assign wr_l    = accept ? in_wr    : wr_q;
  assign addr_l  = accept ? in_addr  : addr_q;
  assign wdata_l = accept ? in_wdata : wdata_q;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt - 8'd1;
    unique case (state)
      IDLE: begin
        cnt_nxt = 8'd0;
        if (start) begin
          nxt     = A_SU;
          cnt_nxt = SU8;
        end
      end
      A_SU: begin
        if (last) begin
          nxt     = A_PW;
          cnt_nxt = PW8;
        end
      end
      A_PW: begin
        if (last) begin
          nxt     = A_HD;
          cnt_nxt = HD8;
        end
      end
      A_HD: begin
        if (last) begin
          nxt     = GAP;
          cnt_nxt = GAP8;
        end
      end
      GAP: begin
        if (last) begin
          nxt     = D_SU;
          cnt_nxt = SU8;
        end
      end
      D_SU: begin
        if (last) begin
          nxt     = D_PW;
          cnt_nxt = PW8;
        end
      end
      D_PW: begin
        if (last) begin
          nxt     = D_HD;
          cnt_nxt = HD8;
        end
      end
      D_HD: begin
        if (last) begin
          nxt     = DONE;
          cnt_nxt = 8'd0;
        end
      end
      DONE: begin
        nxt     = IDLE;
        cnt_nxt = 8'd0;
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = 8'd0;
      end
    endcase
  end

  // Output decode of the upcoming state; registered below.
  always_comb begin
    in_a   = (nxt == A_SU) || (nxt == A_PW) || (nxt == A_HD);
    in_d   = (nxt == D_SU) || (nxt == D_PW) || (nxt == D_HD);
    cs_n_n = !(in_a || in_d);
    ad_n   = in_d;
    cd_n   = in_a || (in_d && wr_l);
    wr_n_n = !((nxt == A_PW) || ((nxt == D_PW) && wr_l));
    rd_n_n = !((nxt == D_PW) && !wr_l);
    busy_n = (nxt != IDLE);
    done_n = (nxt == DONE);
    mux_n  = 8'h00;
    unique case (1'b1)
      in_a:         mux_n = addr_l;
      in_d && wr_l: mux_n = wdata_l;
      default:      mux_n = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 8'd0;
      wr_q             <= 1'b0;
      addr_q           <= 8'h00;
      wdata_q          <= 8'h00;
      out_dato_mux     <= 8'h00;
      flag_direccion   <= 1'b0;
      flag_dato        <= 1'b0;
      controlador_dato <= 1'b0;
      cs_n             <= 1'b1;
      ad               <= 1'b0;
      wr_n             <= 1'b1;
      rd_n             <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      rd_data          <= 8'h00;
    end else begin
      state            <= nxt;
      cnt              <= cnt_nxt;
      out_dato_mux     <= mux_n;
      flag_direccion   <= in_a;
      flag_dato        <= in_d;
      controlador_dato <= cd_n;
      cs_n             <= cs_n_n;
      ad               <= ad_n;
      wr_n             <= wr_n_n;
      rd_n             <= rd_n_n;
      busy             <= busy_n;
      done             <= done_n;
      if (accept) begin
        wr_q    <= in_wr;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
      end
      if ((state == D_PW) && last && !wr_q) begin
        rd_data <= dato_leido;
      end
    end
  end

`ifdef RTCBUS_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_ocupado <= 1'b0;
    end else if (accept) begin
      err_ocupado <= 1'b0;
    end else if (start && busy) begin
      err_ocupado <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rtc_bus_secuenciador.sv
// Scoreboard bench for rtc_bus_secuenciador: random requests vs a
// cycle-index reference model of the bus waveform.
module tb_rtc_bus_secuenciador;

  localparam int SU  = 2;
  localparam int PW  = 10;
  localparam int HD  = 2;
  localparam int GP  = 4;
  localparam int PH  = SU + PW + HD;
  localparam int LEN = 2 * PH + GP + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       in_wr;
  logic [7:0] in_addr;
  logic [7:0] in_wdata;
  logic [7:0] dato_leido;
  logic [7:0] out_dato_mux;
  logic       flag_direccion;
  logic       flag_dato;
  logic       controlador_dato;
  logic       cs_n;
  logic       ad;
  logic       wr_n;
  logic       rd_n;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       err;

  logic       start2;
  logic       wr2;
  logic [7:0] addr2;
  logic [7:0] wdata2;
  logic [7:0] dl2;
  logic [7:0] mux2;
  logic       fdir2;
  logic       fdat2;
  logic       cd2;
  logic       cs_n2;
  logic       ad2;
  logic       wr_n2;
  logic       rd_n2;
  logic       busy2;
  logic       done2;
  logic [7:0] rd_data2;
  logic       err2;

  rtc_bus_secuenciador #(
    .T_SU(SU), .T_PW(PW), .T_HD(HD), .T_GAP(GP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_wr(in_wr),
    .in_addr(in_addr),
    .in_wdata(in_wdata),
    .dato_leido(dato_leido),
    .out_dato_mux(out_dato_mux),
    .flag_direccion(flag_direccion),
    .flag_dato(flag_dato),
    .controlador_dato(controlador_dato),
    .cs_n(cs_n),
    .ad(ad),
    .wr_n(wr_n),
    .rd_n(rd_n),
    .busy(busy),
    .done(done),
    .rd_data(rd_data)
`ifdef RTCBUS_ERR_EN
    ,
    .err_ocupado(err)
`endif
  );

  rtc_bus_secuenciador #(
    .T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1)
  ) dut_fast (
    .clk(clk),
    .reset(reset),
    .start(start2),
    .in_wr(wr2),
    .in_addr(addr2),
    .in_wdata(wdata2),
    .dato_leido(dl2),
    .out_dato_mux(mux2),
    .flag_direccion(fdir2),
    .flag_dato(fdat2),
    .controlador_dato(cd2),
    .cs_n(cs_n2),
    .ad(ad2),
    .wr_n(wr_n2),
    .rd_n(rd_n2),
    .busy(busy2),
    .done(done2),
    .rd_data(rd_data2)
`ifdef RTCBUS_ERR_EN
    ,
    .err_ocupado(err2)
`endif
  );

`ifndef RTCBUS_ERR_EN
  assign err  = 1'b0;
  assign err2 = 1'b0;
`endif

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       err;
  } txn_t;

  txn_t q[$];
  int   total = 0;
  int   bad = 0;
  int   idle_bad = 0;
  int   dato_force = -1;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (dato_force >= 0) dato_leido = 8'(dato_force);
    else dato_leido = 8'($urandom);
  end

  // Monitor: compares every busy cycle against the expected bus shape
  // derived from the busy-cycle index, and settles each request at done.
  int         bc = 0;
  int         cyc_bad = 0;
  bit         orphan = 0;
  logic [7:0] mdl_rd = 8'h00;
  logic [7:0] rd_smp = 8'h00;
  txn_t       cur;
  bit         ia, apw, id, dpw, ok;
  bit         e_cs, e_wr, e_rd, e_cd, e_done;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      bc = 0;
      cyc_bad = 0;
      mdl_rd = 8'h00;
      orphan = 0;
    end else if (busy) begin
      if (q.size() == 0) begin
        if (!orphan) chk("orphan_busy", 1, 0);
        orphan = 1;
      end else begin
        cur = q[0];
        bc++;
        ia  = (bc <= PH);
        apw = (bc > SU) && (bc <= SU + PW);
        id  = (bc > PH + GP) && (bc <= 2 * PH + GP);
        dpw = (bc > PH + GP + SU) && (bc <= PH + GP + SU + PW);
        e_cs   = !(ia || id);
        e_wr   = !((ia && apw) || (id && dpw && cur.wr));
        e_rd   = !(id && dpw && !cur.wr);
        e_cd   = ia || (id && cur.wr);
        e_done = (bc == LEN);
        ok = (cs_n == e_cs) && (wr_n == e_wr) && (rd_n == e_rd) &&
             (flag_direccion == ia) && (flag_dato == id) &&
             (controlador_dato == e_cd) && (done == e_done);
        if (ia && (ad != 1'b0 || out_dato_mux != cur.addr)) ok = 0;
        if (id && ad != 1'b1) ok = 0;
        if (id && cur.wr && out_dato_mux != cur.wdata) ok = 0;
        if (!wr_n && !rd_n) ok = 0;
        if (!ok) begin
          cyc_bad++;
          if (cyc_bad == 1) $display("note: waveform deviates at busy cycle %0d", bc);
        end
        if (!rd_n) rd_smp = dato_leido;
        if (done || bc > LEN + 2) begin
          chk("busy_len", bc, LEN);
          chk("wave", cyc_bad, 0);
          if (cur.wr) begin
            chk("rd_keep", rd_data, mdl_rd);
          end else begin
            chk("rd_data", rd_data, rd_smp);
            mdl_rd = rd_smp;
          end
`ifdef RTCBUS_ERR_EN
          chk("err_ocupado", err, cur.err);
`endif
          void'(q.pop_front());
          bc = 0;
          cyc_bad = 0;
        end
      end
    end else begin
      orphan = 0;
      if (bc != 0) begin
        chk("cut_short", bc, LEN);
        bc = 0;
        cyc_bad = 0;
      end
      if (done || !cs_n || !wr_n || !rd_n || flag_direccion ||
          flag_dato || controlador_dato) idle_bad++;
    end
  end

  task automatic run(input bit wr, input logic [7:0] a, input logic [7:0] d,
                     input bit glitch, input bit hold, input int gap);
    txn_t t;
    in_wr    = wr;
    in_addr  = a;
    in_wdata = d;
    start    = 1'b1;
    t.wr = wr;
    t.addr = a;
    t.wdata = d;
    t.err = glitch || hold;
    q.push_back(t);
    tick();
    for (int i = 1; i <= LEN; i++) begin
      in_wr    = 1'($urandom);
      in_addr  = 8'($urandom);
      in_wdata = 8'($urandom);
      start    = hold;
      if (glitch && i == 5) begin
        start   = 1'b1;
        in_addr = 8'h99;
      end
      tick();
    end
    for (int j = 0; j < gap; j++) begin
      start = 1'b0;
      tick();
    end
  endtask

  task automatic run_fast(input bit wr);
    int nb, nw, nr, nd, ncs, rw, rr, mw, mr;
    nb = 0; nw = 0; nr = 0; nd = 0; ncs = 0;
    rw = 0; rr = 0; mw = 0; mr = 0;
    wr2 = wr;
    addr2 = 8'($urandom);
    wdata2 = 8'($urandom);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy2) nb++;
      if (done2) nd++;
      if (!cs_n2) ncs++;
      if (!wr_n2) begin nw++; rw++; end else rw = 0;
      if (!rd_n2) begin nr++; rr++; end else rr = 0;
      if (rw > mw) mw = rw;
      if (rr > mr) mr = rr;
    end
    tick();
    chk("f_busy", nb, 8);
    chk("f_done", nd, 1);
    chk("f_cs", ncs, 6);
    chk("f_wr", nw, wr ? 2 : 1);
    chk("f_rd", nr, wr ? 0 : 1);
    chk("f_strobe_w", mw + mr, wr ? 1 : 2);
    if (!wr) chk("f_rdd", rd_data2, 8'ha7);
    chk("f_err", err2, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_wr = 1'b0;
    in_addr = 8'h00;
    in_wdata = 8'h00;
    start2 = 1'b0;
    wr2 = 1'b0;
    addr2 = 8'h00;
    wdata2 = 8'h00;
    dl2 = 8'ha7;
    repeat (3) tick();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_rd_n", rd_n, 1);
    chk("rst_ad", ad, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mux", out_dato_mux, 0);
    chk("rst_flags", {flag_direccion, flag_dato, controlador_dato}, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick();

    run(1'b1, 8'h21, 8'h45, 1'b0, 1'b0, 2);
    dato_force = 8'h59;
    run(1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 2);
    dato_force = -1;
    chk("rd_59", rd_data, 8'h59);
    run(1'b1, 8'h30, 8'h7e, 1'b1, 1'b0, 1);

    run(1'b1, 8'h41, 8'h42, 1'b0, 1'b1, 0);
    run(1'b0, 8'h43, 8'h00, 1'b0, 1'b1, 0);
    run(1'b1, 8'h44, 8'h45, 1'b0, 1'b0, 2);

    for (int k = 0; k < 20; k++) begin
      run(1'($urandom), 8'($urandom), 8'($urandom),
          ($urandom_range(0, 3) == 0), 1'($urandom),
          $urandom_range(0, 3));
    end
    start = 1'b0;
    repeat (3) tick();

    dato_force = 8'h3c;
    run(1'b0, 8'h44, 8'h00, 1'b0, 1'b0, 1);
    dato_force = -1;
    chk("rd_3c", rd_data, 8'h3c);
    begin
      txn_t t;
      t.wr = 1'b1;
      t.addr = 8'h55;
      t.wdata = 8'haa;
      t.err = 1'b0;
      in_wr = 1'b1;
      in_addr = 8'h55;
      in_wdata = 8'haa;
      start = 1'b1;
      q.push_back(t);
      tick();
      start = 1'b0;
      repeat (23) tick();
    end
    chk("pre_rst_wr_n", wr_n, 0);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_rst_cs_n", cs_n, 1);
    chk("post_rst_wr_n", wr_n, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rd_data", rd_data, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_ad", ad, 0);
    repeat (40) tick();
    run(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 2);

    run_fast(1'b1);
    run_fast(1'b0);

    repeat (4) tick();
    chk("queue_empty", q.size(), 0);
    chk("idle_clean", idle_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
